// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe game sequencer: stone codes, FSM
// encodings, keypad bit positions and the eight winning-line masks.
package ttt_pkg;

  typedef enum logic [1:0] {
    STONE_EMPTY = 2'd0,
    STONE_X     = 2'd1,
    STONE_O     = 2'd2
  } stone_t;

  typedef enum logic [2:0] {
    ST_MAIN      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_CHECK     = 3'd2,
    ST_OVER_WIN  = 3'd3,
    ST_OVER_DRAW = 3'd4
  } state_t;

  localparam int KEY_STAR = 9;
  localparam int KEY_ZERO = 10;
  localparam int KEY_HASH = 11;

  localparam logic [11:0] NONCELL_KEYS =
    (12'd1 << KEY_STAR) | (12'd1 << KEY_ZERO) | (12'd1 << KEY_HASH);

  // Cell i is bit i, numbered row-major from the top-left corner.
  localparam logic [8:0] LINE_R0 = 9'b000_000_111;
  localparam logic [8:0] LINE_R1 = 9'b000_111_000;
  localparam logic [8:0] LINE_R2 = 9'b111_000_000;
  localparam logic [8:0] LINE_C0 = 9'b001_001_001;
  localparam logic [8:0] LINE_C1 = 9'b010_010_010;
  localparam logic [8:0] LINE_C2 = 9'b100_100_100;
  localparam logic [8:0] LINE_D0 = 9'b100_010_001;
  localparam logic [8:0] LINE_D1 = 9'b001_010_100;

  localparam logic [7:0][8:0] WIN_LINES = {LINE_D1, LINE_D0, LINE_C2, LINE_C1,
                                           LINE_C0, LINE_R2, LINE_R1, LINE_R0};

  function automatic logic is_one_hot(input logic [11:0] v);
    return (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0);
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// Connection bundle between the keypad scanner, the game sequencer and the
// display blocks.
interface ttt_game_ctrl_if;
  // key_data is a plain level (no valid/ready): the scanner holds the decoded
  // key while pressed; every other signal is a registered status level except
  // illegal, which is a single-cycle pulse.
  logic [11:0] key_data;
  logic        is_main;
  logic        turn_o;
  logic [17:0] board;
  logic [2:0]  state;
  logic [1:0]  winner;
  logic [8:0]  win_mask;
  logic [3:0]  move_cnt;
  logic        illegal;

  modport master (
    output key_data,
    input  is_main, turn_o, board, state, winner, win_mask, move_cnt, illegal
  );

  modport slave (
    input  key_data,
    output is_main, turn_o, board, state, winner, win_mask, move_cnt, illegal
  );
endinterface

// File: rtl/ttt_line_check.sv
// Combinational win detector: flags every line fully owned by one stone code
// and ORs their masks together.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  stone_t      stone,
  output logic        win,
  output logic [8:0]  win_mask
);

  logic [7:0] line_hit;

  always_comb begin
    line_hit = '0;
    win_mask = '0;
    for (int l = 0; l < 8; l++) begin
      line_hit[l] = 1'b1;
      for (int c = 0; c < 9; c++) begin
        if (WIN_LINES[l][c] && (board[2*c +: 2] != stone)) line_hit[l] = 1'b0;
      end
      if (line_hit[l]) win_mask = win_mask | WIN_LINES[l];
    end
  end

  assign win = |line_hit;

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: key press edge detection, board/turn ownership,
// win/draw evaluation. Optional per-move timeout under TTT_TURN_TIMEOUT_EN.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  parameter int          TMO_W          = 32
) (
  input  logic            clk,
  input  logic            rst,
  ttt_game_ctrl_if.slave  bus
);

  logic [11:0] key_q, key_prev;
  state_t      state_r;
  logic        is_main_r, turn_r, illegal_r, starter;
  logic [17:0] board_r, placed;
  stone_t      winner_r, last_stone, cur_stone;
  logic [8:0]  mask_r, occ, hit_mask;
  logic [3:0]  cnt_r;
  logic        press, cell_press, occupied, accept, expire, hit;

  assign press      = is_one_hot(key_q) && (key_prev == 12'd0);
  assign cell_press = press && ((key_q & NONCELL_KEYS) == 12'd0);
  assign cur_stone  = turn_r ? STONE_O : STONE_X;
  assign occupied   = |(occ & key_q[8:0]);
  assign accept     = (state_r == ST_PLAY) && cell_press && !occupied;

  always_comb begin
    occ    = '0;
    placed = board_r;
    for (int i = 0; i < 9; i++) begin
      occ[i] = (board_r[2*i +: 2] != 2'b00);
      if (key_q[i]) placed[2*i +: 2] = cur_stone;
    end
  end

  ttt_line_check u_line_check (
    .board    (board_r),
    .stone    (last_stone),
    .win      (hit),
    .win_mask (hit_mask)
  );

`ifdef TTT_TURN_TIMEOUT_EN
  logic [TMO_W-1:0] tmo;

  assign expire = (state_r == ST_PLAY) && (tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        tmo <= '0;
    else if (state_r != ST_PLAY || accept || expire) tmo <= '0;
    else                                            tmo <= tmo + 1'b1;
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q      <= '0;
      key_prev   <= '0;
      state_r    <= ST_MAIN;
      is_main_r  <= 1'b1;
      turn_r     <= 1'b0;
      illegal_r  <= 1'b0;
      starter    <= 1'b0;
      board_r    <= '0;
      winner_r   <= STONE_EMPTY;
      last_stone <= STONE_EMPTY;
      mask_r     <= '0;
      cnt_r      <= '0;
    end else begin
      key_q     <= bus.key_data;
      key_prev  <= key_q;
      illegal_r <= 1'b0;
      case (state_r)
        ST_MAIN: begin
          if (press && key_q[KEY_STAR]) begin
            board_r   <= '0;
            cnt_r     <= '0;
            turn_r    <= starter;
            state_r   <= ST_PLAY;
            is_main_r <= 1'b0;
          end
        end
        ST_PLAY: begin
          // An accepted move outranks a simultaneous timeout expiry.
          if (cell_press) begin
            if (occupied) begin
              illegal_r <= 1'b1;
            end else begin
              board_r    <= placed;
              cnt_r      <= cnt_r + 4'd1;
              last_stone <= cur_stone;
              state_r    <= ST_CHECK;
            end
          end else if (press && key_q[KEY_HASH]) begin
            board_r   <= '0;
            cnt_r     <= '0;
            winner_r  <= STONE_EMPTY;
            mask_r    <= '0;
            state_r   <= ST_MAIN;
            is_main_r <= 1'b1;
          end else if (expire) begin
            turn_r <= ~turn_r;
          end
        end
        ST_CHECK: begin
          if (hit) begin
            winner_r <= last_stone;
            mask_r   <= hit_mask;
            state_r  <= ST_OVER_WIN;
          end else if (cnt_r == 4'd9) begin
            state_r <= ST_OVER_DRAW;
          end else begin
            turn_r  <= ~turn_r;
            state_r <= ST_PLAY;
          end
        end
        ST_OVER_WIN, ST_OVER_DRAW: begin
          if (press && (key_q[KEY_STAR] || key_q[KEY_HASH])) begin
            starter  <= ~starter;
            turn_r   <= ~starter;
            board_r  <= '0;
            cnt_r    <= '0;
            winner_r <= STONE_EMPTY;
            mask_r   <= '0;
            if (key_q[KEY_STAR]) begin
              state_r <= ST_PLAY;
            end else begin
              state_r   <= ST_MAIN;
              is_main_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= ST_MAIN;
          is_main_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.is_main  = is_main_r;
  assign bus.turn_o   = turn_r;
  assign bus.board    = board_r;
  assign bus.state    = state_r;
  assign bus.winner   = winner_r;
  assign bus.win_mask = mask_r;
  assign bus.move_cnt = cnt_r;
  assign bus.illegal  = illegal_r;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: press handling, win/draw, illegal moves,
// key hold/multi-key filtering, async reset and (with the macro) timeout.
module tb_ttt_game_ctrl;

  localparam logic [11:0] K_STAR = 12'h200;
  localparam logic [11:0] K_ZERO = 12'h400;
  localparam logic [11:0] K_HASH = 12'h800;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  ttt_game_ctrl_if bus ();

  ttt_game_ctrl #(.TIMEOUT_CYCLES(10), .TMO_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.key_data = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- drivers ----------------
  // Hold for two edges (press resolved), release for two (CHECK resolved).
  task automatic press_key(input logic [11:0] k);
    bus.key_data = k;
    tick();
    tick();
    bus.key_data = '0;
    tick();
    tick();
  endtask

  task automatic new_game();
    do_reset();
    press_key(K_STAR);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.key_data = '0;
    tick();
    tick();
    n_cmp++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    n_cmp++; if (bus.is_main !== 1'b1) begin n_fail++; $display("FAIL reset_is_main: got %b want 1", bus.is_main); end
    n_cmp++; if (bus.turn_o !== 1'b0) begin n_fail++; $display("FAIL reset_turn: got %b want 0", bus.turn_o); end
    n_cmp++; if (bus.board !== 18'h0) begin n_fail++; $display("FAIL reset_board: got %h want 0", bus.board); end
    n_cmp++; if (bus.winner !== 2'd0) begin n_fail++; $display("FAIL reset_winner: got %0d want 0", bus.winner); end
    n_cmp++; if (bus.win_mask !== 9'h0) begin n_fail++; $display("FAIL reset_mask: got %h want 0", bus.win_mask); end
    n_cmp++; if (bus.move_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.move_cnt); end
    n_cmp++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", bus.illegal); end
    rst = 1'b0;
    press_key(12'h010);
    n_cmp++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL main_ignores_cell: got %0d want 0", bus.state); end
  endtask

  task automatic test_first_move();
    new_game();
    n_cmp++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL start_state: got %0d want 1", bus.state); end
    n_cmp++; if (bus.is_main !== 1'b0) begin n_fail++; $display("FAIL start_is_main: got %b want 0", bus.is_main); end
    n_cmp++; if (bus.turn_o !== 1'b0) begin n_fail++; $display("FAIL start_turn: got %b want 0", bus.turn_o); end
    bus.key_data = 12'h010;
    tick();
    tick();
    n_cmp++; if (bus.board !== 18'h00100) begin n_fail++; $display("FAIL move5_board: got %h want 00100", bus.board); end
    n_cmp++; if (bus.move_cnt !== 4'd1) begin n_fail++; $display("FAIL move5_cnt: got %0d want 1", bus.move_cnt); end
    n_cmp++; if (bus.state !== 3'd2) begin n_fail++; $display("FAIL move5_check: got %0d want 2", bus.state); end
    n_cmp++; if (bus.turn_o !== 1'b0) begin n_fail++; $display("FAIL move5_turn_early: got %b want 0", bus.turn_o); end
    tick();
    n_cmp++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL move5_back_play: got %0d want 1", bus.state); end
    n_cmp++; if (bus.turn_o !== 1'b1) begin n_fail++; $display("FAIL move5_turn: got %b want 1", bus.turn_o); end
    bus.key_data = '0;
    tick();
    tick();
  endtask

  task automatic test_row_win();
    int seq[5] = '{1, 4, 2, 5, 3};
    new_game();
    for (int i = 0; i < 5; i++) press_key(12'h001 << (seq[i] - 1));
    n_cmp++; if (bus.winner !== 2'd1) begin n_fail++; $display("FAIL row_winner: got %0d want 1", bus.winner); end
    n_cmp++; if (bus.win_mask !== 9'h007) begin n_fail++; $display("FAIL row_mask: got %h want 007", bus.win_mask); end
    n_cmp++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL row_state: got %0d want 3", bus.state); end
    n_cmp++; if (bus.board !== 18'h00295) begin n_fail++; $display("FAIL row_board: got %h want 00295", bus.board); end
    n_cmp++; if (bus.move_cnt !== 4'd5) begin n_fail++; $display("FAIL row_cnt: got %0d want 5", bus.move_cnt); end
    n_cmp++; if (bus.turn_o !== 1'b0) begin n_fail++; $display("FAIL row_turn: got %b want 0", bus.turn_o); end
    press_key(12'h100);
    n_cmp++; if (bus.board !== 18'h00295) begin n_fail++; $display("FAIL frozen_board: got %h want 00295", bus.board); end
    n_cmp++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL frozen_state: got %0d want 3", bus.state); end
    n_cmp++; if (bus.move_cnt !== 4'd5) begin n_fail++; $display("FAIL frozen_cnt: got %0d want 5", bus.move_cnt); end
  endtask

  task automatic test_illegal();
    new_game();
    press_key(12'h001);
    bus.key_data = 12'h001;
    tick();
    tick();
    n_cmp++; if (bus.illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse: got %b want 1", bus.illegal); end
    n_cmp++; if (bus.board !== 18'h00001) begin n_fail++; $display("FAIL illegal_board: got %h want 00001", bus.board); end
    n_cmp++; if (bus.turn_o !== 1'b1) begin n_fail++; $display("FAIL illegal_turn: got %b want 1", bus.turn_o); end
    n_cmp++; if (bus.move_cnt !== 4'd1) begin n_fail++; $display("FAIL illegal_cnt: got %0d want 1", bus.move_cnt); end
    n_cmp++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL illegal_state: got %0d want 1", bus.state); end
    tick();
    n_cmp++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_one_cycle: got %b want 0", bus.illegal); end
    bus.key_data = '0;
    tick();
    tick();
  endtask

  task automatic test_draw();
    int seq[9] = '{1, 3, 2, 4, 6, 5, 7, 8, 9};
    new_game();
    for (int i = 0; i < 9; i++) press_key(12'h001 << (seq[i] - 1));
    n_cmp++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL draw_state: got %0d want 4", bus.state); end
    n_cmp++; if (bus.winner !== 2'd0) begin n_fail++; $display("FAIL draw_winner: got %0d want 0", bus.winner); end
    n_cmp++; if (bus.win_mask !== 9'h0) begin n_fail++; $display("FAIL draw_mask: got %h want 0", bus.win_mask); end
    n_cmp++; if (bus.move_cnt !== 4'd9) begin n_fail++; $display("FAIL draw_cnt: got %0d want 9", bus.move_cnt); end
    n_cmp++; if (bus.board !== 18'h196A5) begin n_fail++; $display("FAIL draw_board: got %h want 196a5", bus.board); end
    press_key(K_STAR);
    n_cmp++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL rematch_state: got %0d want 1", bus.state); end
    n_cmp++; if (bus.turn_o !== 1'b1) begin n_fail++; $display("FAIL rematch_turn: got %b want 1", bus.turn_o); end
    n_cmp++; if (bus.board !== 18'h0) begin n_fail++; $display("FAIL rematch_board: got %h want 0", bus.board); end
    n_cmp++; if (bus.move_cnt !== 4'd0) begin n_fail++; $display("FAIL rematch_cnt: got %0d want 0", bus.move_cnt); end
  endtask

  task automatic test_win_on_last();
    int seq[9] = '{2, 1, 4, 3, 6, 7, 9, 8, 5};
    new_game();
    for (int i = 0; i < 9; i++) press_key(12'h001 << (seq[i] - 1));
    n_cmp++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL last_win_state: got %0d want 3", bus.state); end
    n_cmp++; if (bus.winner !== 2'd1) begin n_fail++; $display("FAIL last_win_winner: got %0d want 1", bus.winner); end
    n_cmp++; if (bus.win_mask !== 9'h038) begin n_fail++; $display("FAIL last_win_mask: got %h want 038", bus.win_mask); end
    n_cmp++; if (bus.move_cnt !== 4'd9) begin n_fail++; $display("FAIL last_win_cnt: got %0d want 9", bus.move_cnt); end
    press_key(K_HASH);
    n_cmp++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL over_hash_state: got %0d want 0", bus.state); end
    n_cmp++; if (bus.is_main !== 1'b1) begin n_fail++; $display("FAIL over_hash_is_main: got %b want 1", bus.is_main); end
    n_cmp++; if (bus.winner !== 2'd0) begin n_fail++; $display("FAIL over_hash_winner: got %0d want 0", bus.winner); end
    n_cmp++; if (bus.win_mask !== 9'h0) begin n_fail++; $display("FAIL over_hash_mask: got %h want 0", bus.win_mask); end
    n_cmp++; if (bus.board !== 18'h0) begin n_fail++; $display("FAIL over_hash_board: got %h want 0", bus.board); end
    press_key(K_STAR);
    n_cmp++; if (bus.turn_o !== 1'b1) begin n_fail++; $display("FAIL hash_starter_toggle: got %b want 1", bus.turn_o); end
  endtask

  task automatic test_hold_and_multi();
    logic ill_seen;
    new_game();
    bus.key_data = 12'h001;
    repeat (100) tick();
    bus.key_data = '0;
    tick();
    tick();
    n_cmp++; if (bus.move_cnt !== 4'd1) begin n_fail++; $display("FAIL hold_cnt: got %0d want 1", bus.move_cnt); end
    n_cmp++; if (bus.board !== 18'h00001) begin n_fail++; $display("FAIL hold_board: got %h want 00001", bus.board); end
    ill_seen = 1'b0;
    bus.key_data = 12'h003;
    repeat (10) begin
      tick();
      if (bus.illegal) ill_seen = 1'b1;
    end
    bus.key_data = '0;
    tick();
    tick();
    n_cmp++; if (ill_seen !== 1'b0) begin n_fail++; $display("FAIL multi_illegal: got %b want 0", ill_seen); end
    n_cmp++; if (bus.move_cnt !== 4'd1) begin n_fail++; $display("FAIL multi_cnt: got %0d want 1", bus.move_cnt); end
    n_cmp++; if (bus.board !== 18'h00001) begin n_fail++; $display("FAIL multi_board: got %h want 00001", bus.board); end
  endtask

  task automatic test_hash_to_main();
    new_game();
    press_key(12'h010);
    press_key(K_ZERO);
    press_key(K_STAR);
    n_cmp++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL play_ignore_state: got %0d want 1", bus.state); end
    n_cmp++; if (bus.move_cnt !== 4'd1) begin n_fail++; $display("FAIL play_ignore_cnt: got %0d want 1", bus.move_cnt); end
    n_cmp++; if (bus.board !== 18'h00100) begin n_fail++; $display("FAIL play_ignore_board: got %h want 00100", bus.board); end
    press_key(K_HASH);
    n_cmp++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL play_hash_state: got %0d want 0", bus.state); end
    n_cmp++; if (bus.is_main !== 1'b1) begin n_fail++; $display("FAIL play_hash_is_main: got %b want 1", bus.is_main); end
    n_cmp++; if (bus.board !== 18'h0) begin n_fail++; $display("FAIL play_hash_board: got %h want 0", bus.board); end
  endtask

  task automatic test_reset_mid_play();
    new_game();
    press_key(12'h001);
    bus.key_data = 12'h002;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL async_state: got %0d want 0", bus.state); end
    n_cmp++; if (bus.is_main !== 1'b1) begin n_fail++; $display("FAIL async_is_main: got %b want 1", bus.is_main); end
    n_cmp++; if (bus.board !== 18'h0) begin n_fail++; $display("FAIL async_board: got %h want 0", bus.board); end
    n_cmp++; if (bus.turn_o !== 1'b0) begin n_fail++; $display("FAIL async_turn: got %b want 0", bus.turn_o); end
    n_cmp++; if (bus.move_cnt !== 4'd0) begin n_fail++; $display("FAIL async_cnt: got %0d want 0", bus.move_cnt); end
    bus.key_data = '0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.board !== 18'h0) begin n_fail++; $display("FAIL async_no_write: got %h want 0", bus.board); end
    n_cmp++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL async_stay_main: got %0d want 0", bus.state); end
  endtask

`ifdef TTT_TURN_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bus.key_data = K_STAR;
    tick();
    tick();
    bus.key_data = '0;
    n_cmp++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL tmo_enter: got %0d want 1", bus.state); end
    repeat (9) tick();
    n_cmp++; if (bus.turn_o !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", bus.turn_o); end
    tick();
    n_cmp++; if (bus.turn_o !== 1'b1) begin n_fail++; $display("FAIL tmo_toggle: got %b want 1", bus.turn_o); end
    n_cmp++; if (bus.board !== 18'h0) begin n_fail++; $display("FAIL tmo_board: got %h want 0", bus.board); end
    n_cmp++; if (bus.move_cnt !== 4'd0) begin n_fail++; $display("FAIL tmo_cnt: got %0d want 0", bus.move_cnt); end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.key_data = '0;
    test_reset();
    test_first_move();
    test_row_win();
    test_illegal();
    test_draw();
    test_win_on_last();
    test_hold_and_multi();
    test_hash_to_main();
    test_reset_mid_play();
`ifdef TTT_TURN_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
Game sequencer for the tic-tac-toe board. It consumes the keypad scanner's decoded `key_data` and owns the 3x3 board state, turn, move count and game phase. It detects win/draw and exposes the board plus status to the dot-matrix and 7-segment display blocks. It sits between `keypad_scan` and the display drivers in the TTT top.

Parameters:
- TIMEOUT_CYCLES, 500000000, clk cycles allowed per move before forfeit (used only with the optional feature).
- TMO_W, 32, width of the timeout counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- key_data  input  12  keypad level, one-hot while held; bits 0-8 = keys 1-9 (cells 0-8, row-major), bit 9 = '*', bit 10 = '0', bit 11 = '#'
- is_main  output  1  1 in MAIN phase
- turn_o  output  1  1 = O to move, 0 = X to move
- board  output  18  cell i at [2i+1:2i]; 0 empty, 1 X, 2 O (3 never produced)
- state  output  3  current FSM state encoding
- winner  output  2  0 none, 1 X, 2 O
- win_mask  output  9  cells of the winning line, else 0
- move_cnt  output  4  stones placed, 0-9
- illegal  output  1  one-cycle pulse on a rejected cell press

Behaviour:
- Reset (async, rst=1): state=MAIN, is_main=1, turn_o=0, board=0, winner=0, win_mask=0, move_cnt=0, illegal=0, starter=X, internal key registers=0.
- Press detection:
  - key_data is registered into key_q and then key_prev.
  - press = (key_q is exactly one-hot) && (key_prev==0). One press per key-down.
  - Multi-bit or zero key_q never produces a press. Holding a key produces no repeats.
- MAIN:
  - '*' -> clear board, move_cnt=0, turn_o=starter, go to PLAY.
  - All other keys are ignored.
- PLAY:
  - Cell press, cell empty: write stone (1 if turn_o=0, else 2) and increment move_cnt at the edge ending the press cycle, then go to CHECK.
  - Cell press, cell occupied: illegal=1 for exactly one cycle; board unchanged; stay in PLAY.
  - '#' -> MAIN: clear board, winner=0, win_mask=0.
  - '*' and '0' are ignored.
- CHECK (exactly one cycle; presses are ignored):
  - Evaluate all 8 lines for the stone just placed.
  - Win: winner = that stone, win_mask = the line (if two lines complete at once, OR both masks), go to OVER_WIN.
  - Else if move_cnt==9: go to OVER_DRAW.
  - Else toggle turn_o and go to PLAY.
  - A win on move 9 is a win, not a draw.
- OVER_WIN / OVER_DRAW:
  - The board is frozen.
  - '*' -> toggle starter, clear board, move_cnt, winner and win_mask, set turn_o=new starter, go to PLAY.
  - '#' -> same clearing, then go to MAIN (starter is still toggled).
- Latency: board is visible one edge after the press cycle; winner/state/turn update on the following edge.
- Reset mid-game returns to MAIN immediately, with no completion of the pending write.

Optional Feature:
- Macro TTT_TURN_TIMEOUT_EN.
- Defined:
  - A TMO_W counter clears on entry to PLAY and on every accepted move, and increments each cycle in PLAY.
  - When it reaches TIMEOUT_CYCLES-1, turn_o toggles with no stone placed and move_cnt unchanged, and the counter clears.
  - A press landing in the same cycle as expiry takes priority: the move is accepted and the timeout is discarded.
- Undefined: no counter exists and a player may wait indefinitely.

Decomposition:
- Package ttt_pkg holds:
  - stone codes (EMPTY/X/O)
  - state encodings (MAIN, PLAY, CHECK, OVER_WIN, OVER_DRAW)
  - key bit indices (KEY_STAR=9, KEY_ZERO=10, KEY_HASH=11)
  - the 8 win-line 9-bit mask constants
- One combinational sub-module, ttt_line_check: inputs board and stone; outputs win and win_mask.

Test Plan:
- Reset, then '*' -> state=PLAY, turn_o=0, board=0. Then key 5 (bit 4) -> board[9:8]=1, move_cnt=1, turn_o=1 two edges later.
- X plays 1,2,3 with O on 4,5 -> winner=1, win_mask=9'b000000111, state=OVER_WIN. A later key 9 press changes nothing.
- O presses cell 0 already held by X -> illegal high exactly 1 cycle, board/turn/move_cnt unchanged.
- Full board with no line (X:1,2,6,7,9; O:3,4,5,8) -> state=OVER_DRAW, winner=0, move_cnt=9. Then '*' -> PLAY with turn_o=1 (starter toggled).
- key_data held at bit 0 for 100 cycles -> single stone. Then key_data=12'h003 -> no press, no illegal.
- rst pulsed mid-PLAY -> all outputs take reset values asynchronously. With TTT_TURN_TIMEOUT_EN and TIMEOUT_CYCLES=10, idle 10 cycles in PLAY -> turn_o toggles, board unchanged.
